qpd_demod_packer: RTL and testbench
===================================

Name: qpd_demod_packer

Overview:
- Sits directly downstream of the QPD demodulator.
- Consumes its six low-pass demodulated channels (x1, x2, y1, y2, i1, i2) and the accompanying done strobe.
- Averages 2^DECIM_LOG2 consecutive results per channel.
- Serialises each averaged block as a six-word, ready/valid stream with channel index, frame number and last marker, for the readout/DMA path.
- Flags overruns when the consumer cannot keep up.

Parameters:
- NUM_BITS, default 32: width of each demodulated input channel and of the output word.
- DECIM_LOG2, default 4: log2 of the number of demod results averaged per output block; legal range 0..8.
- FRAME_BITS, default 16: width of the frame counter.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- x1_i, x2_i, y1_i, y2_i, i1_i, i2_i  in  NUM_BITS each  signed demodulated channels; valid only in the cycle where done_i is high.
- done_i  in  1  single-cycle strobe: new result on all six channels.
- data_o  out  NUM_BITS  signed averaged value of the current channel.
- channel_o  out  3  channel index: 0=x1, 1=x2, 2=y1, 3=y2, 4=i1, 5=i2.
- frame_o  out  FRAME_BITS  block sequence number of the word being presented.
- valid_o  out  1  output word valid.
- last_o  out  1  high with channel 5 (the final word of a block).
- ready_i  in  1  consumer accepts the word when valid_o and ready_i are both high.
- overrun_o  out  1  sticky flag: a completed block was dropped.
- clear_overrun_i  in  1  synchronous clear of overrun_o.

Behaviour:
- Reset (asynchronous, reset_i low):
  - All outputs go to 0.
  - Accumulators, sample counter and frame counter go to 0.
  - The sender returns to IDLE.
  - Any block in flight is discarded; no partial block resumes after reset.
- Accumulation:
  - There are six signed accumulators of NUM_BITS+DECIM_LOG2 bits; overflow is impossible by construction.
  - On done_i, each accumulator adds its sign-extended input and the sample counter (DECIM_LOG2 bits) increments.
  - The block completes on the done_i at which the counter equals 2^DECIM_LOG2-1. That sample is included in the sum.
  - On completion, the accumulators restart from 0; the next done_i is the first sample of the next block.
- Averaging:
  - average = sum arithmetically shifted right by DECIM_LOG2 (floor toward minus infinity), truncated to NUM_BITS. This is exact in range.
  - The averages are captured into a six-entry holding register in the completion cycle. The zero-add accumulator restart happens in the same cycle.
  - With DECIM_LOG2=0, every done_i completes a block and the average equals the input.
- Frame counter:
  - Increments on every completed block, whether it is sent or dropped.
  - Wraps modulo 2^FRAME_BITS.
  - Each block is tagged with the counter value before the increment, so the first block is frame 0.
- Sender FSM, states IDLE and SEND (with channel index 0..5):
  - IDLE plus block completion: load the holding register, go to SEND with ch=0. valid_o rises in the next cycle.
  - Latency is 1 cycle from the completing done_i to valid_o.
  - In SEND:
    - valid_o=1; data_o, channel_o and frame_o are held stable until the handshake.
    - On handshake, ch increments.
    - last_o = (ch==5).
    - A handshake on ch=5 returns to IDLE.
  - Handshake on ch=5 in the same cycle as a block completion: the new block is loaded and SEND restarts at ch=0 with no idle cycle. This case is not an overrun.
  - Block completion while in SEND, and not on the final handshake: the new block is dropped, overrun_o is set, and the in-flight block continues unaffected. Accumulation never stalls.
- Overrun flag:
  - Cleared by clear_overrun_i.
  - If a set and a clear occur in the same cycle, the set wins.
- done_i while reset_i is low is ignored.
- No combinational path from any input to any output.

Decomposition:
- Package qpd_pkg holds:
  - NUM_QPD_CHANNELS=6.
  - Enum qpd_channel_e (X1, X2, Y1, Y2, I1, I2) with 3-bit encoding.
  - Enum packer_state_e (IDLE, SEND).
- One sub-module, qpd_block_averager:
  - Contains the six accumulators, the sample counter and the shift/truncate logic.
  - Produces block_done and the six averages.
- The sender FSM and the frame/overrun logic stay in the top module.

Test Plan:
- DECIM_LOG2=2, ready_i=1; four done_i with x1 = 10, 11, 12, 14 (others 0) -> one block, x1 word = 11 (47>>2), others 0, frame 0. valid_o is high 1 cycle after the 4th done_i, and 6 consecutive words are sent with last_o only on ch5.
- Negative floor: x1 = -1, -2, -2, -2 -> word = -2 (sum -7 >> 2).
- Backpressure: hold ready_i=0 for 20 cycles during ch3 -> data_o, channel_o and frame_o stay stable. After ready_i is released, ch3..ch5 follow in 3 cycles; no words are lost or duplicated.
- Overrun: DECIM_LOG2=0, ready_i=0, done_i on two cycles -> first block (frame 0) is held; the second is dropped and overrun_o=1. The next block sent carries frame 2. clear_overrun_i together with a new drop leaves overrun_o=1.
- Back-to-back: ready_i=1, block completion coincides with the ch5 handshake -> next cycle shows ch0 of the new block with valid_o held high, and overrun_o stays 0.
- Reset mid-block: drive reset_i low during ch2 with 3 of 4 samples accumulated -> outputs 0 immediately. After release, the next block needs 4 fresh samples and carries frame 0.
- Frame wrap: FRAME_BITS=4, 17 blocks -> frames run 0..15, then 0.

Source files
------------

// File: rtl/qpd_pkg.sv
// Shared types for the QPD demodulator output packer: channel numbering and
// sender states.
package qpd_pkg;

  localparam int NUM_QPD_CHANNELS = 6;

  typedef enum logic [2:0] {
    X1 = 3'd0,
    X2 = 3'd1,
    Y1 = 3'd2,
    Y2 = 3'd3,
    I1 = 3'd4,
    I2 = 3'd5
  } qpd_channel_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } packer_state_e;

endpackage

// File: rtl/qpd_block_averager.sv
// Six parallel block accumulators with a shared sample counter. Each output is
// the block average (floor of sum / 2^DECIM_LOG2) for the block completing now.
module qpd_block_averager
  import qpd_pkg::*;
#(
  parameter int NUM_BITS   = 32,
  parameter int DECIM_LOG2 = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      done,
  input  logic [NUM_QPD_CHANNELS-1:0][NUM_BITS-1:0] sample,
  output logic                                      block_done,
  output logic [NUM_QPD_CHANNELS-1:0][NUM_BITS-1:0] average
);

  localparam int ACC_W = NUM_BITS + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << DECIM_LOG2) - 1);

  logic [CNT_W-1:0]        cnt_r;
  logic                    last_s;
  logic signed [NUM_BITS-1:0] in_s      [NUM_QPD_CHANNELS];
  logic signed [ACC_W-1:0]    acc_r     [NUM_QPD_CHANNELS];
  logic signed [ACC_W-1:0]    sum_s     [NUM_QPD_CHANNELS];
  logic signed [ACC_W-1:0]    shifted_s [NUM_QPD_CHANNELS];

  assign last_s     = (cnt_r == LAST_CNT);
  assign block_done = done & last_s;

  // Running sum including the current sample; the completing sample is part of the average.
  always_comb begin
    for (int c = 0; c < NUM_QPD_CHANNELS; c++) begin
      in_s[c]      = sample[c];
      sum_s[c]     = acc_r[c] + in_s[c];
      shifted_s[c] = sum_s[c] >>> DECIM_LOG2;
      average[c]   = shifted_s[c][NUM_BITS-1:0];
    end
  end

  // Accumulate on every done; restart from zero on the completing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      for (int c = 0; c < NUM_QPD_CHANNELS; c++) acc_r[c] <= {ACC_W{1'b0}};
    end else if (done) begin
      cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      for (int c = 0; c < NUM_QPD_CHANNELS; c++)
        acc_r[c] <= last_s ? {ACC_W{1'b0}} : sum_s[c];
    end
  end

endmodule

// File: rtl/qpd_demod_packer.sv
// Averages QPD demodulator results per block and streams each block as six
// tagged words over ready/valid; blocks arriving while busy are dropped.
module qpd_demod_packer
  import qpd_pkg::*;
#(
  parameter int NUM_BITS   = 32,
  parameter int DECIM_LOG2 = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_BITS-1:0]   x1_i,
  input  logic [NUM_BITS-1:0]   x2_i,
  input  logic [NUM_BITS-1:0]   y1_i,
  input  logic [NUM_BITS-1:0]   y2_i,
  input  logic [NUM_BITS-1:0]   i1_i,
  input  logic [NUM_BITS-1:0]   i2_i,
  input  logic                  done_i,
  output logic [NUM_BITS-1:0]   data_o,
  output logic [2:0]            channel_o,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  input  logic                  clear_overrun_i
);

  logic [NUM_QPD_CHANNELS-1:0][NUM_BITS-1:0] sample_s;
  logic [NUM_QPD_CHANNELS-1:0][NUM_BITS-1:0] avg_s;
  logic [NUM_QPD_CHANNELS-1:0][NUM_BITS-1:0] hold_r;
  logic                                      blk_done_s;
  packer_state_e                             state_r;
  logic [FRAME_BITS-1:0]                     frame_r;
  logic hs_s, final_hs_s, load_s, drop_s;

  assign sample_s = {i2_i, i1_i, y2_i, y1_i, x2_i, x1_i};

  qpd_block_averager #(
    .NUM_BITS  (NUM_BITS),
    .DECIM_LOG2(DECIM_LOG2)
  ) u_averager (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .done      (done_i),
    .sample    (sample_s),
    .block_done(blk_done_s),
    .average   (avg_s)
  );

  assign valid_o = (state_r == SEND);

  // A completing block is accepted when idle or when the final word leaves this cycle.
  always_comb begin
    hs_s       = (state_r == SEND) & ready_i;
    final_hs_s = hs_s & (channel_o == 3'(I2));
    load_s     = blk_done_s & ((state_r == IDLE) | final_hs_s);
    drop_s     = blk_done_s & ~load_s;
  end

  // Sender: load a block, then step through channels on each handshake.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r   <= IDLE;
      hold_r    <= {NUM_QPD_CHANNELS{{NUM_BITS{1'b0}}}};
      channel_o <= 3'd0;
      data_o    <= {NUM_BITS{1'b0}};
      frame_o   <= {FRAME_BITS{1'b0}};
      last_o    <= 1'b0;
    end else if (load_s) begin
      state_r   <= SEND;
      hold_r    <= avg_s;
      channel_o <= 3'(X1);
      data_o    <= avg_s[0];
      frame_o   <= frame_r;
      last_o    <= 1'b0;
    end else if (hs_s) begin
      if (final_hs_s) begin
        state_r   <= IDLE;
        channel_o <= 3'd0;
        data_o    <= {NUM_BITS{1'b0}};
        frame_o   <= {FRAME_BITS{1'b0}};
        last_o    <= 1'b0;
      end else begin
        channel_o <= channel_o + 3'd1;
        data_o    <= hold_r[channel_o + 3'd1];
        last_o    <= (channel_o == 3'(I1));
      end
    end
  end

  // Frame count advances on every completed block; a drop sets the sticky overrun (set beats clear).
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      frame_r   <= {FRAME_BITS{1'b0}};
      overrun_o <= 1'b0;
    end else begin
      if (blk_done_s) frame_r <= frame_r + FRAME_BITS'(1);
      if (drop_s)               overrun_o <= 1'b1;
      else if (clear_overrun_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpd_demod_packer.sv
// Randomized and directed bench for qpd_demod_packer: two instances (4-sample
// blocks with 16-bit frames, 1-sample blocks with 4-bit frames) vs a word-queue model.
module tb_qpd_demod_packer;

  typedef struct {
    longint data;
    int     ch;
    int     frame;
    bit     last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset_i, done_i, clear_overrun_i;
  logic [31:0] smp [6];
  logic        ready [2];
  logic [31:0] data_w [2];
  logic [2:0]  ch_w [2];
  logic        valid_w [2], last_w [2], ovr_w [2];
  logic [15:0] frame_a;
  logic [3:0]  frame_b;

  int n_vec = 0;
  int n_err = 0;

  word_t  wq [2][$];
  longint acc_m [2][6];
  int     cnt_m [2];
  int     frame_m [2];
  bit     ovr_m [2];

  always #5 clk = ~clk;

  qpd_demod_packer #(.NUM_BITS(32), .DECIM_LOG2(2), .FRAME_BITS(16)) u_dut_a (
    .clk_i(clk), .reset_i(reset_i),
    .x1_i(smp[0]), .x2_i(smp[1]), .y1_i(smp[2]), .y2_i(smp[3]), .i1_i(smp[4]), .i2_i(smp[5]),
    .done_i(done_i), .data_o(data_w[0]), .channel_o(ch_w[0]), .frame_o(frame_a),
    .valid_o(valid_w[0]), .last_o(last_w[0]), .ready_i(ready[0]),
    .overrun_o(ovr_w[0]), .clear_overrun_i(clear_overrun_i)
  );

  qpd_demod_packer #(.NUM_BITS(32), .DECIM_LOG2(0), .FRAME_BITS(4)) u_dut_b (
    .clk_i(clk), .reset_i(reset_i),
    .x1_i(smp[0]), .x2_i(smp[1]), .y1_i(smp[2]), .y2_i(smp[3]), .i1_i(smp[4]), .i2_i(smp[5]),
    .done_i(done_i), .data_o(data_w[1]), .channel_o(ch_w[1]), .frame_o(frame_b),
    .valid_o(valid_w[1]), .last_o(last_w[1]), .ready_i(ready[1]),
    .overrun_o(ovr_w[1]), .clear_overrun_i(clear_overrun_i)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nsamp(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int fmod(input int k);
    return (k == 0) ? 65536 : 16;
  endfunction

  function automatic longint frame_of(input int k);
    return (k == 0) ? longint'(frame_a) : longint'(frame_b);
  endfunction

  function automatic longint floor_div(input longint s, input longint n);
    longint q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      wq[k].delete();
      for (int c = 0; c < 6; c++) acc_m[k][c] = 0;
      cnt_m[k] = 0; frame_m[k] = 0; ovr_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit    drop;
    word_t w;
    drop = 1'b0;
    if (wq[k].size() > 0 && ready[k]) void'(wq[k].pop_front());
    if (done_i) begin
      for (int c = 0; c < 6; c++) acc_m[k][c] += longint'($signed(smp[c]));
      cnt_m[k]++;
      if (cnt_m[k] == nsamp(k)) begin
        if (wq[k].size() == 0) begin
          for (int c = 0; c < 6; c++) begin
            w.data = floor_div(acc_m[k][c], longint'(nsamp(k)));
            w.ch = c; w.frame = frame_m[k]; w.last = (c == 5);
            wq[k].push_back(w);
          end
        end else begin
          drop = 1'b1;
        end
        for (int c = 0; c < 6; c++) acc_m[k][c] = 0;
        cnt_m[k] = 0;
        frame_m[k] = (frame_m[k] + 1) % fmod(k);
      end
    end
    if (clear_overrun_i) ovr_m[k] = 1'b0;
    if (drop) ovr_m[k] = 1'b1;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("valid[%0d]", k), longint'(valid_w[k]), longint'(wq[k].size() > 0));
      check_eq($sformatf("overrun[%0d]", k), longint'(ovr_w[k]), longint'(ovr_m[k]));
      if (wq[k].size() > 0 && valid_w[k]) begin
        check_eq($sformatf("data[%0d]", k), longint'($signed(data_w[k])), wq[k][0].data);
        check_eq($sformatf("channel[%0d]", k), longint'(ch_w[k]), longint'(wq[k][0].ch));
        check_eq($sformatf("frame[%0d]", k), frame_of(k), longint'(wq[k][0].frame));
        check_eq($sformatf("last[%0d]", k), longint'(last_w[k]), longint'(wq[k][0].last));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_data[%0d]", tag, k), longint'(data_w[k]), 0);
      check_eq($sformatf("%s_chan[%0d]", tag, k), longint'(ch_w[k]), 0);
      check_eq($sformatf("%s_frame[%0d]", tag, k), frame_of(k), 0);
      check_eq($sformatf("%s_valid[%0d]", tag, k), longint'(valid_w[k]), 0);
      check_eq($sformatf("%s_last[%0d]", tag, k), longint'(last_w[k]), 0);
      check_eq($sformatf("%s_ovr[%0d]", tag, k), longint'(ovr_w[k]), 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_i) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_outputs();
  endtask

  task automatic set_samples(input int x1, input bit rnd);
    for (int c = 0; c < 6; c++) smp[c] = rnd ? 32'($urandom) : 32'd0;
    if (!rnd) smp[0] = 32'(x1);
  endtask

  task automatic done_cycle(input int x1, input bit rnd);
    set_samples(x1, rnd);
    done_i = 1'b1;
    cycle();
    done_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    ready[0] = 1'b1; ready[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (wq[0].size() == 0 && wq[1].size() == 0) break;
      cycle();
    end
    check_eq({tag, "_idle_a"}, longint'(valid_w[0]), 0);
    check_eq({tag, "_idle_b"}, longint'(valid_w[1]), 0);
  endtask

  task automatic wait_chan(input string tag, input int ch);
    for (int i = 0; i < 20; i++) begin
      if (valid_w[0] && ch_w[0] == 3'(ch)) break;
      cycle();
    end
    check_eq(tag, longint'(ch_w[0]), longint'(ch));
  endtask

  initial begin
    logic [31:0] held_data;
    logic [15:0] held_frame;
    int          xs [4];

    reset_i = 1'b0; done_i = 1'b0; clear_overrun_i = 1'b0;
    ready[0] = 1'b1; ready[1] = 1'b1;
    set_samples(0, 1'b0);
    model_reset();
    repeat (3) cycle();
    check_zero("reset");
    reset_i = 1'b1;
    cycle();

    // Basic block: x1 = 10,11,12,14 -> 11, frame 0.
    xs = '{10, 11, 12, 14};
    for (int i = 0; i < 4; i++) begin
      done_cycle(xs[i], 1'b0);
      if (i < 3) cycle();
    end
    check_eq("first_x1", longint'($signed(data_w[0])), 11);
    check_eq("first_frame", longint'(frame_a), 0);
    drain("basic");

    // Negative floor: -1,-2,-2,-2 -> -2.
    xs = '{-1, -2, -2, -2};
    for (int i = 0; i < 4; i++) done_cycle(xs[i], 1'b0);
    check_eq("neg_x1", longint'($signed(data_w[0])), -2);
    drain("neg");

    // Backpressure on channel 3 for 20 cycles.
    for (int i = 0; i < 4; i++) done_cycle(0, 1'b1);
    wait_chan("bp_reach_ch3", 3);
    ready[0] = 1'b0;
    held_data = data_w[0]; held_frame = frame_a;
    repeat (20) begin
      cycle();
      check_eq("bp_data_stable", longint'(data_w[0]), longint'(held_data));
      check_eq("bp_frame_stable", longint'(frame_a), longint'(held_frame));
      check_eq("bp_chan_stable", longint'(ch_w[0]), 3);
    end
    ready[0] = 1'b1;
    repeat (3) cycle();
    drain("bp");
    clear_overrun_i = 1'b1; cycle(); clear_overrun_i = 1'b0;

    // Overrun on the 1-sample instance, then set-beats-clear.
    ready[1] = 1'b0;
    done_cycle(0, 1'b1);
    done_cycle(0, 1'b1);
    check_eq("ovr_set", longint'(ovr_w[1]), 1);
    clear_overrun_i = 1'b1;
    done_cycle(0, 1'b1);
    clear_overrun_i = 1'b0;
    check_eq("ovr_set_wins", longint'(ovr_w[1]), 1);
    drain("ovr");
    done_cycle(0, 1'b1);
    drain("ovr2");
    clear_overrun_i = 1'b1; cycle(); clear_overrun_i = 1'b0;

    // Reset during channel 2 with three samples already accumulated.
    for (int i = 0; i < 4; i++) done_cycle(0, 1'b1);
    wait_chan("rst_reach_ch2", 2);
    ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) done_cycle(0, 1'b1);
    reset_i = 1'b0;
    model_reset();
    #1;
    check_zero("midreset");
    done_cycle(0, 1'b1);
    cycle();
    reset_i = 1'b1; ready[0] = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) done_cycle(0, 1'b1);
    check_eq("fresh_not_done", longint'(valid_w[0]), 0);
    done_cycle(0, 1'b1);
    check_eq("fresh_frame0", longint'(frame_a), 0);
    drain("fresh");
    clear_overrun_i = 1'b1; cycle(); clear_overrun_i = 1'b0;

    // Back-to-back: completion lands on the channel-5 handshake.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) done_cycle(0, 1'b1);
      if (r < 2) repeat (2) cycle();
    end
    for (int i = 0; i < 8; i++) begin
      check_eq("b2b_ovr_a", longint'(ovr_w[0]), 0);
      cycle();
    end
    drain("b2b");

    // Frame wrap on the 4-bit frame counter.
    reset_i = 1'b0; model_reset(); #1; cycle();
    reset_i = 1'b1; cycle();
    for (int i = 0; i < 17; i++) begin
      done_cycle(0, 1'b1);
      check_eq("wrap_frame_b", longint'(frame_b), longint'(i % 16));
      repeat (7) cycle();
    end
    drain("wrap");

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      set_samples(0, 1'b1);
      done_i = ($urandom_range(0, 2) == 0);
      ready[0] = ($urandom_range(0, 3) != 0);
      ready[1] = ($urandom_range(0, 3) != 0);
      clear_overrun_i = ($urandom_range(0, 15) == 0);
      cycle();
    end
    done_i = 1'b0; clear_overrun_i = 1'b0;
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
